lut_arbiter: RTL and testbench

//  Shares one synchronous-read lookup ROM (1-cycle read latency, ena-gated) among N_REQ requesters,
//  e.g. the I/Q carrier NCOs and the code-phase path of the GPS signal generator.

---
 rtl/lut_arb_pkg.sv | 32 +++
 rtl/rr_picker.sv | 26 ++
 rtl/lut_arbiter.sv | 103 ++++++++++
 tb/tb_lut_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_arb_pkg.sv
// Shared constants and the round-robin pick function for the LUT arbiter.
// Used by lut_arbiter and rr_picker.
package lut_arb_pkg;

  localparam int LUT_RD_LATENCY = 1;
  localparam int MAX_REQ        = 8;
  localparam int MAX_PTR_W      = 3;

  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Scan ptr, ptr+1, ... modulo n; the first valid requester wins.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [MAX_PTR_W-1:0] ptr,
                                                 input int n);
    logic [MAX_REQ-1:0]   grant;
    logic                 found;
    logic [MAX_PTR_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = MAX_PTR_W'((int'(ptr) + k) % n);
      if (k < n && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority picker: valid vector and pointer in,
// one-hot grant out (all-zero when nothing is valid).
module rr_picker
  import lut_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant
);

  logic [MAX_REQ-1:0] w_grant_full;

  assign w_grant_full = rr_pick(MAX_REQ'(i_valid), MAX_PTR_W'(i_ptr), N_REQ);
  assign o_grant      = w_grant_full[N_REQ-1:0];

  generate
    if (N_REQ < MAX_REQ) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = |w_grant_full[MAX_REQ-1:N_REQ];
    end
  endgenerate

endmodule

// File: rtl/lut_arbiter.sv
// Round-robin sharing of one synchronous-read lookup ROM among N_REQ requesters.
// Optional macro LUT_ARB_RSP_REG_EN adds a registered response stage (latency 2).
module lut_arbiter
  import lut_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ADDR_LENGTH = 8,
  parameter int WORD_LENGTH = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [N_REQ-1:0]             req_valid_in,
  input  logic [N_REQ*ADDR_LENGTH-1:0] req_addr_in,
  output logic [N_REQ-1:0]             req_ready_out,
  output logic [N_REQ-1:0]             rsp_valid_out,
  output logic [WORD_LENGTH-1:0]       rsp_data_out,
  output logic                         lut_ena_out,
  output logic [ADDR_LENGTH-1:0]       lut_addr_out,
  input  logic [WORD_LENGTH-1:0]       lut_data_in
);

  localparam int PTR_W = ptr_width(N_REQ);

  logic [PTR_W-1:0]       r_rr_ptr;
  logic [PTR_W-1:0]       w_rr_ptr_next;
  logic [N_REQ-1:0]       w_pick;
  logic [N_REQ-1:0]       w_grant;
  logic [N_REQ-1:0]       w_rsp_sel;
  logic [ADDR_LENGTH-1:0] w_addr;
  logic [N_REQ-1:0]       r_rsp_pipe [LUT_RD_LATENCY];

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .i_valid (req_valid_in),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick)
  );

  // Nothing is granted or issued to the ROM while reset is held.
  assign w_grant       = rst_in ? '0 : w_pick;
  assign req_ready_out = w_grant;
  assign lut_ena_out   = ~rst_in & (|req_valid_in);
  assign lut_addr_out  = w_addr;

  always_comb begin
    w_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_addr = w_addr | ({ADDR_LENGTH{w_grant[i]}} & req_addr_in[i*ADDR_LENGTH +: ADDR_LENGTH]);
    end
  end

  always_comb begin
    w_rr_ptr_next = r_rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_rr_ptr_next = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // Grant tag follows the ROM read pipeline so each word reaches its requester.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rr_ptr <= '0;
      for (int k = 0; k < LUT_RD_LATENCY; k++) begin
        r_rsp_pipe[k] <= '0;
      end
    end else begin
      r_rr_ptr      <= w_rr_ptr_next;
      r_rsp_pipe[0] <= w_grant;
      for (int k = 1; k < LUT_RD_LATENCY; k++) begin
        r_rsp_pipe[k] <= r_rsp_pipe[k-1];
      end
    end
  end

  assign w_rsp_sel = r_rsp_pipe[LUT_RD_LATENCY-1];

`ifdef LUT_ARB_RSP_REG_EN
  logic [N_REQ-1:0]       r_rsp_valid;
  logic [WORD_LENGTH-1:0] r_rsp_data;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_rsp_sel;
      r_rsp_data  <= lut_data_in;
    end
  end

  assign rsp_valid_out = rst_in ? '0 : r_rsp_valid;
  assign rsp_data_out  = rst_in ? '0 : r_rsp_data;
`else
  // Gating with reset drops a response whose request was accepted just before reset.
  assign rsp_valid_out = rst_in ? '0 : w_rsp_sel;
  assign rsp_data_out  = lut_data_in;
`endif

endmodule

// File: tb/tb_lut_arbiter.sv
// Self-checking bench for lut_arbiter: one N_REQ=2 and one N_REQ=4 instance,
// each with a behavioural ROM (mem[a] = a ^ 16'hA5A5, one-cycle read).
module tb_lut_arbiter;

`ifdef LUT_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          idx;
    logic [15:0] data;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  v2, rdy2, rv2;
  logic [15:0] a2, rd2, ld2;
  logic        ena2;
  logic [7:0]  la2;
  logic [3:0]  v4, rdy4, rv4;
  logic [31:0] a4;
  logic [15:0] rd4, ld4;
  logic        ena4;
  logic [7:0]  la4;

  lut_arbiter #(.N_REQ(2), .ADDR_LENGTH(8), .WORD_LENGTH(16)) dut2 (
    .clk_in(clk), .rst_in(rst), .req_valid_in(v2), .req_addr_in(a2),
    .req_ready_out(rdy2), .rsp_valid_out(rv2), .rsp_data_out(rd2),
    .lut_ena_out(ena2), .lut_addr_out(la2), .lut_data_in(ld2));

  lut_arbiter #(.N_REQ(4), .ADDR_LENGTH(8), .WORD_LENGTH(16)) dut4 (
    .clk_in(clk), .rst_in(rst), .req_valid_in(v4), .req_addr_in(a4),
    .req_ready_out(rdy4), .rsp_valid_out(rv4), .rsp_data_out(rd4),
    .lut_ena_out(ena4), .lut_addr_out(la4), .lut_data_in(ld4));

  function automatic logic [15:0] rom(input logic [7:0] a);
    return {8'h00, a} ^ 16'hA5A5;
  endfunction

  always @(posedge clk) begin
    if (ena2) ld2 <= rom(la2);
    if (ena4) ld4 <= rom(la4);
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: round-robin pointer and in-flight response queue per instance.
  int   mptr2 = 0, mptr4 = 0;
  rsp_t q2[$];
  rsp_t q4[$];
  int   g2, g4;
  logic [1:0]  e_rdy2, e_rv2;
  logic [3:0]  e_rdy4, e_rv4;
  logic        e_ena2, e_ena4;
  logic [7:0]  e_la2, e_la4;
  logic [15:0] e_rd2, e_rd4;

  function automatic int pick(input int n, input logic [7:0] valid, input int ptr);
    for (int k = 0; k < n; k++) begin
      if (valid[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic eval();
    #1;
    g2     = rst ? -1 : pick(2, {6'b0, v2}, mptr2);
    e_rdy2 = (g2 < 0) ? 2'b00 : 2'(1 << g2);
    e_la2  = (g2 < 0) ? 8'h00 : a2[g2*8 +: 8];
    e_ena2 = !rst && (v2 != 0);
    if (!rst && q2.size() == LAT && q2[0].idx >= 0) begin
      e_rv2 = 2'(1 << q2[0].idx);
      e_rd2 = q2[0].data;
    end else begin
      e_rv2 = '0;
      e_rd2 = '0;
    end
    g4     = rst ? -1 : pick(4, {4'b0, v4}, mptr4);
    e_rdy4 = (g4 < 0) ? 4'b0000 : 4'(1 << g4);
    e_la4  = (g4 < 0) ? 8'h00 : a4[g4*8 +: 8];
    e_ena4 = !rst && (v4 != 0);
    if (!rst && q4.size() == LAT && q4[0].idx >= 0) begin
      e_rv4 = 4'(1 << q4[0].idx);
      e_rd4 = q4[0].data;
    end else begin
      e_rv4 = '0;
      e_rd4 = '0;
    end
  endtask

  task automatic advance();
    if (rst) begin
      mptr2 = 0;
      mptr4 = 0;
      q2.delete();
      q4.delete();
    end else begin
      if (g2 >= 0) mptr2 = (g2 + 1) % 2;
      if (g4 >= 0) mptr4 = (g4 + 1) % 4;
      if (q2.size() == LAT) void'(q2.pop_front());
      if (q4.size() == LAT) void'(q4.pop_front());
      q2.push_back('{g2, (g2 >= 0) ? rom(e_la2) : 16'h0000});
      q4.push_back('{g4, (g4 >= 0) ? rom(e_la4) : 16'h0000});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; v2 = 2'b11; v4 = 4'hF;
    a2 = 16'($urandom); a4 = $urandom;
    repeat (3) begin
      eval();
      checks++;
      if ({rdy2, rv2, ena2, la2, rdy4, rv4, ena4, la4} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: rdy2=%b rv2=%b ena2=%b la2=%h rdy4=%b rv4=%b ena4=%b la4=%h, want all zero",
                 rdy2, rv2, ena2, la2, rdy4, rv4, ena4, la4);
      end
`ifdef LUT_ARB_RSP_REG_EN
      checks++;
      if (rd2 !== 16'h0000 || rd4 !== 16'h0000) begin
        errors++;
        $display("FAIL reset_data: rd2=%h rd4=%h, want 0000", rd2, rd4);
      end
`endif
      advance();
    end
    rst = 1'b0;
    eval();
    checks++;
    if (rdy2 !== 2'b01 || rdy4 !== 4'b0001) begin
      errors++;
      $display("FAIL first_grant: rdy2=%b rdy4=%b, want 01 and 0001", rdy2, rdy4);
    end
    advance();
    v2 = 2'b00; v4 = 4'b0000;
    repeat (LAT + 1) begin
      eval();
      checks++;
      if ({rdy2, ena2, la2, rv2} !== {e_rdy2, e_ena2, e_la2, e_rv2} || (e_rv2 != 0 && rd2 !== e_rd2)) begin
        errors++;
        $display("FAIL reset_drain2: rdy=%b ena=%b addr=%h rsp=%b data=%h, want %b %b %h %b %h",
                 rdy2, ena2, la2, rv2, rd2, e_rdy2, e_ena2, e_la2, e_rv2, e_rd2);
      end
      advance();
    end
  endtask

  task automatic test_single();
    v2 = 2'b10; a2 = {8'h3C, 8'h55};
    eval();
    checks++;
    if (rdy2 !== 2'b10 || la2 !== 8'h3C || ena2 !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: rdy=%b addr=%h ena=%b, want 10 3c 1", rdy2, la2, ena2);
    end
    advance();
    v2 = 2'b00;
    for (int c = 1; c <= LAT + 1; c++) begin
      eval();
      checks++;
      if ((c == LAT) ? (rv2 !== 2'b10 || rd2 !== 16'hA599) : (rv2 !== 2'b00)) begin
        errors++;
        $display("FAIL single_rsp c=%0d: rsp=%b data=%h, want %b data a599", c, rv2, rd2,
                 (c == LAT) ? 2'b10 : 2'b00);
      end
      advance();
    end
  endtask

  task automatic test_contention();
    logic [1:0] prev;
    v2 = 2'b11;
    prev = 2'b00;
    for (int c = 0; c < 10 + LAT; c++) begin
      if (c == 10) v2 = 2'b00;
      a2 = 16'($urandom);
      eval();
      checks++;
      if ({rdy2, ena2, la2, rv2} !== {e_rdy2, e_ena2, e_la2, e_rv2} || (e_rv2 != 0 && rd2 !== e_rd2)) begin
        errors++;
        $display("FAIL contention c=%0d: rdy=%b ena=%b addr=%h rsp=%b data=%h, want %b %b %h %b %h",
                 c, rdy2, ena2, la2, rv2, rd2, e_rdy2, e_ena2, e_la2, e_rv2, e_rd2);
      end
      if (c > 0 && c < 10) begin
        checks++;
        if (rdy2 !== ~prev) begin
          errors++;
          $display("FAIL contention_alternate c=%0d: rdy=%b, want %b", c, rdy2, ~prev);
        end
      end
      prev = rdy2;
      advance();
    end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] exp_tab [3];
    exp_tab[0] = 4'b1000; exp_tab[1] = 4'b0001; exp_tab[2] = 4'b1000;
    v4 = 4'b0001; a4 = $urandom;
    eval();
    checks++;
    if (rdy4 !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_setup: rdy4=%b, want 0001", rdy4);
    end
    advance();
    v4 = 4'b1001;
    for (int c = 0; c < 3 + LAT; c++) begin
      if (c == 3) v4 = 4'b0000;
      a4 = $urandom;
      eval();
      if (c < 3) begin
        checks++;
        if (rdy4 !== exp_tab[c]) begin
          errors++;
          $display("FAIL wrap_grant c=%0d: rdy4=%b, want %b", c, rdy4, exp_tab[c]);
        end
      end
      checks++;
      if ({rdy4, ena4, la4, rv4} !== {e_rdy4, e_ena4, e_la4, e_rv4} || (e_rv4 != 0 && rd4 !== e_rd4)) begin
        errors++;
        $display("FAIL wrap_model c=%0d: rdy=%b ena=%b addr=%h rsp=%b data=%h, want %b %b %h %b %h",
                 c, rdy4, ena4, la4, rv4, rd4, e_rdy4, e_ena4, e_la4, e_rv4, e_rd4);
      end
      advance();
    end
  endtask

  task automatic test_reset_midflight();
    v2 = 2'b01; a2 = 16'h0042;
    eval();
    advance();
    rst = 1'b1; v2 = 2'b00;
    repeat (2) begin
      eval();
      checks++;
      if (rv2 !== 2'b00) begin
        errors++;
        $display("FAIL midflight_in_reset: rsp=%b, want 00", rv2);
      end
      advance();
    end
    rst = 1'b0;
    repeat (LAT + 1) begin
      eval();
      checks++;
      if (rv2 !== 2'b00) begin
        errors++;
        $display("FAIL midflight_after_reset: rsp=%b, want 00", rv2);
      end
      advance();
    end
    v2 = 2'b11;
    eval();
    checks++;
    if (rdy2 !== 2'b01) begin
      errors++;
      $display("FAIL midflight_ptr_cleared: rdy=%b, want 01", rdy2);
    end
    advance();
    v2 = 2'b00;
    repeat (LAT + 1) begin
      eval();
      advance();
    end
  endtask

  task automatic test_cancel();
    int rsp0_count;
    rsp0_count = 0;
    v2 = 2'b01; a2 = 16'h0020;
    for (int c = 0; c < LAT + 4; c++) begin
      if (c == 1) begin
        v2 = 2'b11; a2 = {8'h11, 8'h77};
      end else if (c == 2) begin
        v2 = 2'b00;
      end
      eval();
      if (c == 1) begin
        checks++;
        if (rdy2 !== 2'b10 || la2 !== 8'h11) begin
          errors++;
          $display("FAIL cancel_grant: rdy=%b addr=%h, want 10 11", rdy2, la2);
        end
      end
      checks++;
      if (la2 === 8'h77 || (rv2[0] === 1'b1 && rd2 === rom(8'h77))) begin
        errors++;
        $display("FAIL cancel_issued: addr=%h rsp=%b data=%h, want no access to 77", la2, rv2, rd2);
      end
      if (rv2[0] === 1'b1) rsp0_count++;
      advance();
    end
    checks++;
    if (rsp0_count != 1) begin
      errors++;
      $display("FAIL cancel_rsp0_count: got %0d, want 1", rsp0_count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      v2 = 2'($urandom); a2 = 16'($urandom);
      v4 = 4'($urandom); a4 = $urandom;
      eval();
      checks++;
      if ({rdy2, ena2, la2, rv2} !== {e_rdy2, e_ena2, e_la2, e_rv2} || (e_rv2 != 0 && rd2 !== e_rd2)) begin
        errors++;
        $display("FAIL random2 c=%0d: rdy=%b ena=%b addr=%h rsp=%b data=%h, want %b %b %h %b %h",
                 c, rdy2, ena2, la2, rv2, rd2, e_rdy2, e_ena2, e_la2, e_rv2, e_rd2);
      end
      checks++;
      if ({rdy4, ena4, la4, rv4} !== {e_rdy4, e_ena4, e_la4, e_rv4} || (e_rv4 != 0 && rd4 !== e_rd4)) begin
        errors++;
        $display("FAIL random4 c=%0d: rdy=%b ena=%b addr=%h rsp=%b data=%h, want %b %b %h %b %h",
                 c, rdy4, ena4, la4, rv4, rd4, e_rdy4, e_ena4, e_la4, e_rv4, e_rd4);
      end
      advance();
    end
    rst = 1'b0; v2 = 2'b00; v4 = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; v2 = 2'b00; a2 = '0; v4 = 4'b0000; a4 = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_wrap_skip();
    test_reset_midflight();
    test_cancel();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
